// File: rtl/regfile_write_arbiter.sv
// Two-port write arbiter for the register file. Round-robin between
// requesters, optional multi-write lock, and a watchdog that frees a lock
// whose owner stops requesting. One registered write command per cycle.
module regfile_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_lock,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              last_grant,
  output logic              lock_abort,
  output logic [15:0]       wr_count
);

  // Counter only ever holds 0 .. LOCK_TIMEOUT-1; the abort fires instead of
  // storing LOCK_TIMEOUT itself.
  localparam int CNT_W = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              last_grant_q, last_grant_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic ready0, ready1;
  logic fire0, fire1;
  logic abort;

  // Ready generation, transfer detection, next-state and command datapath.
  // NOTE: every signal assigned in this always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    ready0       = 1'b0;
    ready1       = 1'b0;
    abort        = 1'b0;
    state_d      = state_q;
    idle_cnt_d   = '0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;
    wr_count_d   = wr_count_q;

    unique case (state_q)
      FREE: begin
        ready0 = req0_valid && (!req1_valid || last_grant_q);
        ready1 = req1_valid && (!req0_valid || !last_grant_q);
      end
      LOCK0:   ready0 = req0_valid;
      LOCK1:   ready1 = req1_valid;
      default: ;
    endcase

    // Nobody is ready while reset is held, even combinationally.
    if (reset) begin
      ready0 = 1'b0;
      ready1 = 1'b0;
    end

    fire0   = req0_valid && ready0;
    fire1   = req1_valid && ready1;
    wr_en_d = fire0 || fire1;

    if (fire0) begin
      wr_addr_d    = req0_addr;
      wr_data_d    = req0_data;
      last_grant_d = 1'b0;
      wr_count_d   = wr_count_q + 16'd1;
    end else if (fire1) begin
      wr_addr_d    = req1_addr;
      wr_data_d    = req1_data;
      last_grant_d = 1'b1;
      wr_count_d   = wr_count_q + 16'd1;
    end

    unique case (state_q)
      FREE: begin
        if (fire0 && req0_lock)      state_d = LOCK0;
        else if (fire1 && req1_lock) state_d = LOCK1;
      end
      LOCK0: begin
        // Owner activity always beats the watchdog on the same cycle.
        if (fire0) begin
          if (!req0_lock) state_d = FREE;
        end else if (idle_cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = FREE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      LOCK1: begin
        if (fire1) begin
          if (!req1_lock) state_d = FREE;
        end else if (idle_cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = FREE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = FREE;
    endcase
  end

  // State and registered write command; reset drops any pending command.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FREE;
      idle_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      last_grant_q <= 1'b1;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      last_grant_q <= last_grant_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign req0_ready = ready0;
  assign req1_ready = ready1;
  assign lock_abort = abort;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign last_grant = last_grant_q;
  assign wr_count   = wr_count_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16x32 register file between two requesters, e.g. an execute unit (port 0) and a load unit (port 1).
- Uses valid/ready handshakes and round-robin priority. A requester may lock the port for a multi-write burst.
- Issues one registered write command per cycle: wr_en, wr_addr and wr_data drive the register file's load enable, decoder select and data input.
- A watchdog frees a lock whose owner goes idle.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 4, width of register index (16 registers).
- LOCK_TIMEOUT, 8, consecutive idle owner cycles after which a lock is force-released (>=1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  ADDR_W  destination register, requester 0
- req0_data  input  DATA_W  write data, requester 0
- req0_lock  input  1  keep ownership after this transfer
- req0_ready  output  1  requester 0 transfer accepted this cycle if valid
- req1_valid, req1_addr, req1_data, req1_lock, req1_ready  same as port 0, for requester 1
- wr_en  output  1  register file load enable
- wr_addr  output  ADDR_W  register file write select
- wr_data  output  DATA_W  register file write data
- last_grant  output  1  index of the last accepted requester
- lock_abort  output  1  one-cycle pulse when the watchdog frees a lock
- wr_count  output  16  total accepted writes, wraps 0xFFFF->0x0000

Behaviour:
- Reset (async, active-high):
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, last_grant=1 (so requester 0 wins the first tie), lock_abort=0, wr_count=0.
  - Internal: state=FREE, idle counter=0.
  - req0_ready and req1_ready are forced to 0 while reset is high.
- Handshake:
  - readyN is combinational from state, valid inputs and last_grant. At most one ready is high per cycle.
  - A transfer occurs on a clock edge where validN && readyN.
  - Requesters hold addr/data/lock stable while valid and not ready.
- Latency: accepted transfer at edge T -> wr_en=1 with that addr/data during cycle T+1. The next back-to-back transfer may be accepted at edge T+1 (throughput 1 write/cycle).
- wr_en behaviour:
  - wr_en=0 in any cycle following an edge with no transfer.
  - wr_addr/wr_data hold their last values when wr_en=0.
- States:
  - FREE:
    - One valid -> that requester is ready.
    - Both valid -> the requester != last_grant is ready.
    - Neither valid -> no ready.
  - LOCK0 / LOCK1: only the owner may be ready; the other requester is stalled even if the port is idle.
- Transitions:
  - FREE -> LOCKk on a transfer from k with reqk_lock=1.
  - LOCKk -> FREE on a transfer from k with reqk_lock=0; that final transfer is still written.
  - LOCKk stays in LOCKk on a transfer from k with lock=1.
- last_grant and wr_count: last_grant updates to k on every transfer from k. wr_count increments on every transfer.
- Watchdog:
  - In LOCKk, the idle counter increments on each cycle with reqk_valid=0 and clears on any reqk_valid=1.
  - When the counter reaches LOCK_TIMEOUT: state -> FREE, counter -> 0, lock_abort=1 for exactly one cycle, no write issued.
  - The idle counter is 0 in FREE.
- Simultaneous events:
  - If the owner asserts valid on the same cycle the counter would reach LOCK_TIMEOUT, the valid wins: the transfer is accepted and there is no abort.
  - After an abort, FREE arbitration applies from the next cycle. Round-robin still uses last_grant, so the other requester wins a tie.
- Reset mid-burst: state returns to FREE, and any command already presented on wr_en is dropped (wr_en=0 immediately).

Test Plan:
- Single requester: req0 writes addr 3, data 0xFFFFFF03 at edge T -> wr_en=1, wr_addr=3, wr_data=0xFFFFFF03 at T+1, wr_en=0 at T+2, wr_count=1.
- Round-robin: both valid continuously for 4 cycles, addrs 1 (req0) and 2 (req1) -> grant order 0,1,0,1, wr_addr sequence 1,2,1,2, back-to-back wr_en, wr_count=4.
- Lock burst: req1 sends addrs 5,6,7 with lock=1,1,0 while req0 is held valid -> req0_ready=0 throughout, writes 5,6,7, then req0 is granted next.
- Watchdog: req0 locks and then drops valid for 8 cycles while req1 is valid -> lock_abort pulses once on the 8th idle cycle, and req1 is accepted the following cycle.
- Timeout race: owner reasserts valid exactly on the 8th idle cycle -> transfer accepted, lock_abort stays 0.
- Async reset mid-lock with wr_en=1 -> all outputs return to their reset values without a clock edge, readys=0, and after release the first tie goes to req0.
